// File: rtl/gen_scheduler.sv
// Generation scheduler: paces next-state engine runs, gates commits on vblank, handles clear.
// Ports: clk, reset (async, active-high), run, step, clear, rate_sel[1:0], vblank, eng_done
//   in; eng_start, commit, clear_o (pulses), generation[15:0], busy out.
// Optional feature: define GEN_SCHED_VBLANK_SYNC_EN to hold commits until vblank=1.
module gen_scheduler #(
  parameter int BASE_TICKS = 25000000,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        clear,
  input  logic [1:0]  rate_sel,
  input  logic        vblank,
  input  logic        eng_done,
  output logic        eng_start,
  output logic        commit,
  output logic        clear_o,
  output logic [15:0] generation,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, START, COMPUTE, WAIT_VB, COMMIT, CLEAR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period, period_m1;
  logic             gen_pend_q, gen_pend_d;
  logic             clr_pend_q, clr_pend_d;
  logic [15:0]      generation_q, generation_d;
  logic             tick, gen_req;

  assign period    = CNT_W'(BASE_TICKS) << rate_sel;
  assign period_m1 = period - CNT_W'(1);

  // >= rather than == so a shrinking period fires at once instead of
  // running the counter all the way around.
  assign tick    = run & (count_q >= period_m1);
  assign gen_req = tick | (step & ~run);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (!run || tick) count_d = '0;
  end

`ifndef GEN_SCHED_VBLANK_SYNC_EN
  logic vblank_unused;
  assign vblank_unused = vblank;
`endif

  always_comb begin
    state_d      = state_q;
    eng_start    = 1'b0;
    commit       = 1'b0;
    clear_o      = 1'b0;
    gen_pend_d   = gen_pend_q | gen_req;
    clr_pend_d   = clr_pend_q | clear;
    generation_d = generation_q;
    unique case (state_q)
      IDLE: begin
        if (clr_pend_q)      state_d = CLEAR;
        else if (gen_pend_q) state_d = START;
      end
      START: begin
        eng_start  = 1'b1;
        // A request arriving while the current one is consumed is dropped.
        gen_pend_d = 1'b0;
        state_d    = COMPUTE;
      end
      COMPUTE: begin
        if (eng_done) begin
          if (clr_pend_q) state_d = CLEAR;
          else            state_d = WAIT_VB;
        end
      end
      WAIT_VB: begin
`ifdef GEN_SCHED_VBLANK_SYNC_EN
        if (vblank) state_d = COMMIT;
`else
        state_d = COMMIT;
`endif
      end
      COMMIT: begin
        commit       = 1'b1;
        generation_d = generation_q + 16'd1;
        state_d      = IDLE;
      end
      CLEAR: begin
        clear_o      = 1'b1;
        generation_d = '0;
        gen_pend_d   = 1'b0;
        clr_pend_d   = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      gen_pend_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
      generation_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      gen_pend_q   <= gen_pend_d;
      clr_pend_q   <= clr_pend_d;
      generation_q <= generation_d;
    end
  end

  assign generation = generation_q;
  assign busy       = (state_q != IDLE);

endmodule
